// File: rtl/midi_note_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | midi_note_tx : key-vector to MIDI Note On/Off messages on a UART 8N1 line  |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module midi_note_tx #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 31_250,
  parameter int BASE_NOTE = 60,
  parameter int CHANNEL   = 0,
  parameter int OFF_VEL   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key,
  input  logic [4:0] pitchshift,
  input  logic [6:0] volume,
  input  logic       ena,
  output logic       tx,
  output logic       busy
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [7:0]    ON_STATUS  = 8'h90 | 8'(CHANNEL & 15);
  localparam logic [7:0]    OFF_STATUS = 8'h80 | 8'(CHANNEL & 15);
  localparam logic [7:0]    OFF_VEL_B  = 8'(OFF_VEL);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [23:0]   msg_q, msg_d;
  logic [9:0]    sent_q, sent_d;
  logic [6:0]    held_note_q [10];
  logic [6:0]    held_note_d [10];
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic [9:0] eff;
  logic [9:0] diff;
  logic [3:0] sel_idx;
  logic [8:0] note_sum;
  logic [6:0] note_n;
  logic [7:0] cur_byte;
  logic       cnt_last;

  assign eff      = ena ? key : 10'b0;
  assign diff     = eff ^ sent_q;
  assign cnt_last = (cnt_q == CNT_LAST);

  // Descending scan so the lowest pending index is the last one written.
  always_comb begin
    sel_idx = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (diff[i]) sel_idx = 4'(i);
    end
  end

  // Range is -16..151, so bit 8 is a reliable sign bit for the clamp.
  assign note_sum = 9'(BASE_NOTE) + {5'd0, sel_idx} + {{4{pitchshift[4]}}, pitchshift};

  always_comb begin
    if (note_sum[8])      note_n = 7'd0;
    else if (note_sum[7]) note_n = 7'd127;
    else                  note_n = note_sum[6:0];
  end

  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = msg_q[7:0];
      2'd1:    cur_byte = msg_q[15:8];
      default: cur_byte = msg_q[23:16];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_last ? '0 : cnt_q + CW'(1);
    bit_d       = bit_q;
    byte_d      = byte_q;
    msg_d       = msg_q;
    sent_d      = sent_q;
    held_note_d = held_note_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        bit_d  = 3'd0;
        byte_d = 2'd0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (diff != 10'b0) begin
          sent_d[sel_idx] = eff[sel_idx];
          if (eff[sel_idx]) begin
            held_note_d[sel_idx] = note_n;
            msg_d = {1'b0, volume, 1'b0, note_n, ON_STATUS};
          end else begin
            msg_d = {OFF_VEL_B, 1'b0, held_note_q[sel_idx], OFF_STATUS};
          end
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (cnt_last) begin
          state_d = S_DATA;
          tx_d    = cur_byte[0];
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            bit_d   = 3'd0;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end
      end
      default: begin
        if (cnt_last) begin
          if (byte_q != 2'd2) begin
            byte_d  = byte_q + 2'd1;
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            byte_d  = 2'd0;
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      byte_q      <= 2'd0;
      msg_q       <= 24'd0;
      sent_q      <= 10'b0;
      held_note_q <= '{default: 7'd0};
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      msg_q       <= msg_d;
      sent_q      <= sent_d;
      held_note_q <= held_note_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_note_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_midi_note_tx : directed + random bench for midi_note_tx (DIV = 16)      |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_midi_note_tx;

  localparam int DIV = 16;
  localparam int MSG = 30 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] key, key_hi, key_lo;
  logic [4:0] ps, ps_hi, ps_lo;
  logic [6:0] vol;
  logic       ena;
  logic       tx_a, busy_a, tx_b, busy_b, tx_c, busy_c;
  int         sel;
  logic       mon_tx, mon_busy;

  int checks = 0;
  int errors = 0;

  logic [9:0] sent_m;
  logic [7:0] held_m [10];
  int         drop_msg = -1;

  always #5 clk = ~clk;

  midi_note_tx #(.CLK_HZ(16), .BAUD(1), .BASE_NOTE(60), .CHANNEL(0), .OFF_VEL(64)) dut (
    .clk(clk), .rst(rst), .key(key), .pitchshift(ps), .volume(vol), .ena(ena),
    .tx(tx_a), .busy(busy_a));

  midi_note_tx #(.CLK_HZ(16), .BAUD(1), .BASE_NOTE(125), .CHANNEL(0), .OFF_VEL(64)) dut_hi (
    .clk(clk), .rst(rst), .key(key_hi), .pitchshift(ps_hi), .volume(vol), .ena(ena),
    .tx(tx_b), .busy(busy_b));

  midi_note_tx #(.CLK_HZ(16), .BAUD(1), .BASE_NOTE(0), .CHANNEL(0), .OFF_VEL(64)) dut_lo (
    .clk(clk), .rst(rst), .key(key_lo), .pitchshift(ps_lo), .volume(vol), .ena(ena),
    .tx(tx_c), .busy(busy_c));

  always_comb begin
    case (sel)
      1:       begin mon_tx = tx_b; mon_busy = busy_b; end
      2:       begin mon_tx = tx_c; mon_busy = busy_c; end
      default: begin mon_tx = tx_a; mon_busy = busy_a; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Note number straight from the rule: base + index + signed shift, clamped to 0..127.
  function automatic logic [7:0] model_note(input int base, input int idx, input logic [4:0] p);
    int s;
    int n;
    s = int'(p);
    if (s > 15) s = s - 32;
    n = base + idx + s;
    if (n < 0)   n = 0;
    if (n > 127) n = 127;
    return 8'(n);
  endfunction

  // Captures one whole message cycle by cycle; every message is expected to start
  // on the negedge right after its decision edge and last exactly MSG cycles.
  task automatic run_msg(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input int drop_k);
    logic       rec [MSG];
    logic [7:0] ex  [3];
    logic [7:0] got;
    int         w, bad_busy, frame, base;
    ex[0] = e0; ex[1] = e1; ex[2] = e2;
    w = 0; bad_busy = 0; frame = 0;
    @(negedge clk);
    while (!mon_busy && w < 4 * MSG) begin
      w++;
      @(negedge clk);
    end
    chk({tag, " start_latency"}, w, 0);
    for (int k = 0; k < MSG; k++) begin
      rec[k] = mon_tx;
      if (!mon_busy) bad_busy++;
      if (k == drop_k) ena = 1'b0;
      @(negedge clk);
    end
    chk({tag, " busy_len"}, bad_busy, 0);
    chk({tag, " end_idle"}, {30'd0, mon_busy, mon_tx}, 32'd1);
    for (int j = 0; j < 3; j++) begin
      base = j * 10 * DIV;
      if (rec[base + DIV/2] !== 1'b0)         frame++;
      if (rec[base + 9*DIV + DIV/2] !== 1'b1) frame++;
      for (int b = 0; b < 8; b++) got[b] = rec[base + (b + 1) * DIV + DIV/2];
      chk($sformatf("%s byte%0d", tag, j), got, ex[j]);
    end
    chk({tag, " framing"}, frame, 0);
  endtask

  // Drives a new key vector and expects one message per changed bit, lowest first.
  task automatic apply_eff(input logic [9:0] k);
    logic [9:0] eff;
    int         m;
    m   = 0;
    key = k;
    eff = ena ? k : 10'b0;
    for (int i = 0; i < 10; i++) begin
      if (eff[i] !== sent_m[i]) begin
        if (eff[i]) begin
          held_m[i] = model_note(60, i, ps);
          run_msg($sformatf("on%0d", i), 8'h90, held_m[i], {1'b0, vol},
                  (m == drop_msg) ? 200 : -1);
        end else begin
          run_msg($sformatf("off%0d", i), 8'h80, held_m[i], 8'h40,
                  (m == drop_msg) ? 200 : -1);
        end
        sent_m[i] = eff[i];
        m++;
      end
    end
  endtask

  initial begin
    int bad;
    logic [9:0] mask;
    rst = 1'b1; key = '0; key_hi = '0; key_lo = '0;
    ps = '0; ps_hi = '0; ps_lo = '0; vol = 7'd100; ena = 1'b1; sel = 0;
    sent_m = '0;
    for (int i = 0; i < 10; i++) held_m[i] = 8'd0;

    repeat (3) @(negedge clk);
    chk("reset_out_a", {30'd0, busy_a, tx_a}, 32'd1);
    chk("reset_out_bc", {28'd0, busy_b, tx_b, busy_c, tx_c}, 32'd5);
    rst = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy_a || !tx_a) bad++;
    end
    chk("idle_after_reset", bad, 0);

    // Note On key 0, then Note Off after a pitch change reuses the stored note.
    apply_eff(10'b0000000001);
    ps = 5'b00011;
    apply_eff(10'b0000000000);
    ps = 5'b00000;

    // Two simultaneous presses, serialised with one idle cycle between them.
    apply_eff(10'b1000000100);
    apply_eff(10'b0000000000);

    // ena dropped mid-message: Note Offs follow in ascending order.
    drop_msg = 1;
    apply_eff(10'b0000010010);
    drop_msg = -1;
    chk("ena_dropped", {31'd0, ena}, 32'd0);
    apply_eff(10'b0000010010);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_a || !tx_a) bad++;
    end
    chk("idle_after_ena_off", bad, 0);
    ena = 1'b1;
    apply_eff(10'b0000010010);

    // Randomised key changes with random shift and velocity.
    for (int it = 0; it < 10; it++) begin
      ps   = 5'($urandom_range(0, 31));
      vol  = 7'($urandom_range(0, 127));
      mask = (10'd1 << $urandom_range(0, 9)) | (10'd1 << $urandom_range(0, 9));
      apply_eff(key ^ mask);
    end
    apply_eff(10'b0000000000);

    // Reset during data bit 3 of byte 1 with key 2 already sounding.
    ps  = 5'd0;
    vol = 7'd90;
    apply_eff(10'b0000000100);
    key = 10'b0000100100;
    bad = 0;
    @(negedge clk);
    while (!busy_a && bad < 100) begin
      bad++;
      @(negedge clk);
    end
    chk("rst_test_start", bad, 0);
    repeat (230) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_abort", {30'd0, busy_a, tx_a}, 32'd1);
    rst = 1'b0;
    sent_m = '0;
    for (int i = 0; i < 10; i++) held_m[i] = 8'd0;
    apply_eff(10'b0000100100);
    apply_eff(10'b0000000000);

    // Clamp boundaries on the alternate-base instances.
    vol   = 7'd100;
    sel   = 1;
    ps_hi = 5'd15;
    key_hi = 10'b1000000000;
    run_msg("clamp_hi", 8'h90, model_note(125, 9, 5'd15), {1'b0, vol}, -1);
    sel   = 2;
    ps_lo = 5'b10000;
    key_lo = 10'b0000000001;
    run_msg("clamp_lo", 8'h90, model_note(0, 0, 5'b10000), {1'b0, vol}, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
